multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore FSM that sequences the shared multicycle RV32I datapath: one ALU, one unified instruction/data memory port, and registered IR/OldPC/Data/ALUOut.
- Issues per-state mux selects and write enables for lw, sw, R-type, I-type ALU, beq and jal.
- Stalls on a memory ready handshake.
- Decodes ALU and immediate controls from the instruction register fields.
- Sits beside the multicycle datapath inside the multicycle processor top.

Parameters:
- MEM_WAIT_EN, 1, 1: honour mem_ready; 0: treat mem_ready as constant 1 (single-cycle memory).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- op  input  7  Instr[6:0] from IR
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- Zero  input  1  ALU zero flag
- mem_ready  input  1  memory access completes this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  0 = PC, 1 = ALUOut/Result as memory address
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  IR and OldPC enable
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1
- ALUSrcB  output  2  00 rs2, 01 ImmExt, 10 constant 4
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
- RegWrite  output  1  register file write enable
- illegal  output  1  sticky unsupported-opcode flag
- state_dbg  output  4  current state encoding

Behaviour:
- State register updates on the rising clk edge. reset=1 forces FETCH at the next edge.
- All outputs are combinational from state, plus decoder inputs, Zero and mem_ready.
- While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
- After reset: state FETCH, illegal=0.
- Defaults in every state: all enables 0, selects 00, ALUOp=00.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - mem_ready=1 → DECODE; else stay in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - any other → ERROR
- MEMADR: ALUSrcA=10, ALUSrcB=01. op[5]=0 → MEMREAD; op[5]=1 → MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready=1 → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until mem_ready=1 → FETCH. Address and data must stay stable meanwhile (no datapath enables asserted).
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1 → ALUWB (rd = PC+4).
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero → FETCH.
- ERROR: all enables 0, illegal=1. Absorbing state; only reset exits.
- Cycle counts from FETCH with mem_ready=1:
  - lw 5, sw 4
  - R/I-type 4, jal 4, beq 3
- Each extra cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- ALU decoder:
  - ALUOp 00 → add; 01 → sub.
  - ALUOp 10, funct3 000: sub if op[5]&funct7b5, else add.
  - ALUOp 10, funct3 010 → slt; 110 → or; 111 → and; other funct3 → add.
- ImmSrc decode from op:
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - else 00
- Reset asserted mid-instruction (any state, including a MEMWRITE stall) aborts the instruction. No enable may be asserted in the reset cycle.

Decomposition:
- Package riscv_mc_pkg holds:
  - state_t enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ, ERROR) in 4 bits
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ)
  - ALUOp and ALUControl encodings
  - ResultSrc, ALUSrcA and ALUSrcB select constants
- Sub-module mc_alu_decoder: combinational ALUOp/funct3/funct7b5/op5 → ALUControl.
- FSM and ImmSrc decode stay in the top.

Test Plan:
- reset=1 for 2 cycles, then release → state_dbg=FETCH, illegal=0, all enables 0 during reset.
- lw (op 0000011), mem_ready=1 throughout → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with ResultSrc=01 in cycle 5.
- sw (op 0100011), mem_ready low 3 cycles in MEMWRITE → MemWrite=1 for 4 consecutive cycles, AdrSrc=1, ImmSrc=01; return to FETCH after mem_ready=1.
- beq with Zero=1 and then Zero=0 → in BEQ, ALUControl=001 and PCWrite=1 then 0; each instruction takes 3 cycles.
- R-type sub (funct3 000, funct7b5=1), then addi with funct7b5=1 → EXECR ALUControl=001; EXECI ALUControl=000; ALUWB RegWrite=1.
- op 1111111 → DECODE goes to ERROR, illegal=1 and held over 10 cycles; reset clears to FETCH with illegal=0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller:
// FSM states, opcodes, ALU controls and datapath select codes.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        JAL,
        BEQ,
        ERROR
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2 = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        logic [1:0] r;
        r = IMM_I;
        case (op)
            OP_SW:   r = IMM_S;
            OP_BEQ:  r = IMM_B;
            OP_JAL:  r = IMM_J;
            default: r = IMM_I;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle from the multicycle controller to the shared datapath.
// The controller drives it (master); the datapath consumes it (slave).
interface mc_ctrl_if;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       illegal;
    logic [3:0] state_dbg;

    modport master (
        output PCWrite, AdrSrc, MemWrite, IRWrite,
        output ResultSrc, ALUSrcA, ALUSrcB,
        output ALUControl, ImmSrc, RegWrite,
        output illegal, state_dbg
    );

    modport slave (
        input PCWrite, AdrSrc, MemWrite, IRWrite,
        input ResultSrc, ALUSrcA, ALUSrcB,
        input ALUControl, ImmSrc, RegWrite,
        input illegal, state_dbg
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from ALUOp and the IR funct fields.
module mc_alu_decoder
    import riscv_mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FN: begin
                case (funct3)
                    // addi never subtracts: op5 is 0 for I-type
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared multicycle RV32I datapath,
// with memory-ready stalls and a sticky illegal-opcode trap.
module multicycle_controller
    import riscv_mc_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal,
    output logic [3:0] state_dbg
);
    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic       rdy;
    logic       pc_write, ir_write, mem_write, reg_write;

    assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                ALUSrcB   = SRCB_4;
                ResultSrc = RES_ALURES;
                ir_write  = rdy;
                pc_write  = rdy;
                if (rdy) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
                    default:      state_d = ERROR;
                endcase
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (rdy) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            // strobe held; nothing else moves so address/data stay put
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                if (rdy) state_d = FETCH;
            end
            EXECR: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_FN;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FN;
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_4;
                pc_write = 1'b1;
                state_d  = ALUWB;
            end
            BEQ: begin
                ALUSrcA  = SRCA_RS1;
                alu_op   = ALUOP_SUB;
                pc_write = Zero;
                state_d  = FETCH;
            end
            ERROR:   state_d = ERROR;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    assign PCWrite   = pc_write & ~reset;
    assign IRWrite   = ir_write & ~reset;
    assign MemWrite  = mem_write & ~reset;
    assign RegWrite  = reg_write & ~reset;
    assign ImmSrc    = imm_src(op);
    assign illegal   = (state_q == ERROR);
    assign state_dbg = state_q;

    mc_alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed table, corner sequences
// and random instruction streams against a path-based reference model.
module tb_multicycle_controller;
    import riscv_mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = OP_LW;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;

    mc_ctrl_if cif ();

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (cif.PCWrite),
        .AdrSrc     (cif.AdrSrc),
        .MemWrite   (cif.MemWrite),
        .IRWrite    (cif.IRWrite),
        .ResultSrc  (cif.ResultSrc),
        .ALUSrcA    (cif.ALUSrcA),
        .ALUSrcB    (cif.ALUSrcB),
        .ALUControl (cif.ALUControl),
        .ImmSrc     (cif.ImmSrc),
        .RegWrite   (cif.RegWrite),
        .illegal    (cif.illegal),
        .state_dbg  (cif.state_dbg)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       mw;
        logic       rw;
        logic       adr;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] alu;
        logic [1:0] imm;
        logic       ill;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         sm;
        int         cyc;
        logic [1:0] imm;
        string      name;
    } vec_t;

    state_t path[$];
    logic   mrq[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic outs_t act_outs();
        return {cif.PCWrite, cif.IRWrite, cif.MemWrite, cif.RegWrite,
                cif.AdrSrc, cif.ResultSrc, cif.ALUSrcA, cif.ALUSrcB,
                cif.ALUControl, cif.ImmSrc, cif.illegal};
    endfunction

    // Arithmetic meaning of an R/I instruction mapped to its ALU code
    function automatic logic [2:0] exec_alu(input logic [6:0] o,
                                            input logic [2:0] f3,
                                            input logic f7);
        if (f3 == 3'd0) return (o == OP_R && f7) ? ALU_SUB : ALU_ADD;
        if (f3 == 3'd2) return ALU_SLT;
        if (f3 == 3'd6) return ALU_OR;
        if (f3 == 3'd7) return ALU_AND;
        return ALU_ADD;
    endfunction

    function automatic logic [1:0] imm_exp(input logic [6:0] o);
        if (o == OP_SW)  return 2'b01;
        if (o == OP_BEQ) return 2'b10;
        if (o == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic outs_t expect_for(input state_t st, input logic mr,
                                         input logic z, input logic [6:0] o,
                                         input logic [2:0] f3, input logic f7);
        outs_t e;
        e = '0;
        e.imm = imm_exp(o);
        e.alu = ALU_ADD;
        case (st)
            FETCH:    begin e.pcw = mr; e.irw = mr; e.sb = 2'b10; e.res = 2'b10; end
            DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; end
            MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
            MEMREAD:  e.adr = 1'b1;
            MEMWB:    begin e.res = 2'b01; e.rw = 1'b1; end
            MEMWRITE: begin e.adr = 1'b1; e.mw = 1'b1; end
            EXECR:    begin e.sa = 2'b10; e.alu = exec_alu(o, f3, f7); end
            EXECI:    begin e.sa = 2'b10; e.sb = 2'b01; e.alu = exec_alu(o, f3, f7); end
            ALUWB:    e.rw = 1'b1;
            JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            BEQ:      begin e.sa = 2'b10; e.alu = ALU_SUB; e.pcw = z; end
            ERROR:    e.ill = 1'b1;
            default:  e = '0;
        endcase
        return e;
    endfunction

    function automatic void push(input state_t s, input logic m);
        path.push_back(s);
        mrq.push_back(m);
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Path of states an instruction walks, with the mem_ready to drive
    task automatic build(input logic [6:0] o, input int sf, input int sm);
        path.delete();
        mrq.delete();
        repeat (sf) push(FETCH, 1'b0);
        push(FETCH, 1'b1);
        push(DECODE, rnd());
        if (o == OP_LW) begin
            push(MEMADR, rnd());
            repeat (sm) push(MEMREAD, 1'b0);
            push(MEMREAD, 1'b1);
            push(MEMWB, rnd());
        end else if (o == OP_SW) begin
            push(MEMADR, rnd());
            repeat (sm) push(MEMWRITE, 1'b0);
            push(MEMWRITE, 1'b1);
        end else if (o == OP_R) begin
            push(EXECR, rnd());
            push(ALUWB, rnd());
        end else if (o == OP_I) begin
            push(EXECI, rnd());
            push(ALUWB, rnd());
        end else if (o == OP_JAL) begin
            push(JAL, rnd());
            push(ALUWB, rnd());
        end else if (o == OP_BEQ) begin
            push(BEQ, rnd());
        end else begin
            push(ERROR, rnd());
        end
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z,
                             input int sf, input int sm, input string tag,
                             output int seen, output logic [1:0] imm_seen);
        build(o, sf, sm);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        Zero = z;
        seen = 1;
        imm_seen = 2'bxx;
        for (int i = 0; i < path.size(); i++) begin
            mem_ready = mrq[i];
            @(negedge clk);
            if (i == 0) imm_seen = cif.ImmSrc;
            if (cif.state_dbg != 4'(FETCH)) seen++;
            chk({tag, " state"}, 32'(cif.state_dbg), 32'(path[i]));
            chk({tag, " outs"}, 32'(act_outs()),
                32'(expect_for(path[i], mrq[i], z, o, f3, f7)));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic enables_off(input string tag);
        chk({tag, " enables"},
            32'({cif.PCWrite, cif.IRWrite, cif.MemWrite, cif.RegWrite}),
            32'(0));
    endtask

    task automatic do_reset_to_fetch(input string tag);
        reset = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        enables_off({tag, " in reset"});
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        chk({tag, " state"}, 32'(cif.state_dbg), 32'(FETCH));
        chk({tag, " illegal"}, 32'(cif.illegal), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[11];
        int         seen;
        int         k;
        logic [1:0] imm_seen;
        logic [6:0] ops[6];

        tbl[0]  = '{OP_LW,  3'd2, 1'b0, 1'b0, 0, 5, 2'b00, "lw"};
        tbl[1]  = '{OP_SW,  3'd2, 1'b0, 1'b0, 3, 7, 2'b01, "sw stall3"};
        tbl[2]  = '{OP_BEQ, 3'd0, 1'b0, 1'b1, 0, 3, 2'b10, "beq taken"};
        tbl[3]  = '{OP_BEQ, 3'd0, 1'b0, 1'b0, 0, 3, 2'b10, "beq not"};
        tbl[4]  = '{OP_R,   3'd0, 1'b1, 1'b0, 0, 4, 2'b00, "sub"};
        tbl[5]  = '{OP_I,   3'd0, 1'b1, 1'b0, 0, 4, 2'b00, "addi f7"};
        tbl[6]  = '{OP_R,   3'd2, 1'b0, 1'b0, 0, 4, 2'b00, "slt"};
        tbl[7]  = '{OP_R,   3'd6, 1'b0, 1'b0, 0, 4, 2'b00, "or"};
        tbl[8]  = '{OP_I,   3'd7, 1'b0, 1'b0, 0, 4, 2'b00, "andi"};
        tbl[9]  = '{OP_JAL, 3'd0, 1'b0, 1'b0, 0, 4, 2'b11, "jal"};
        tbl[10] = '{OP_LW,  3'd2, 1'b0, 1'b0, 2, 7, 2'b00, "lw stall2"};

        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};

        // Reset held across two sampled cycles
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            enables_off("reset");
        end
        chk("reset state", 32'(cif.state_dbg), 32'(FETCH));
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("post-reset state", 32'(cif.state_dbg), 32'(FETCH));
        chk("post-reset illegal", 32'(cif.illegal), 32'(0));
        chk("fetch stall pcwrite", 32'(cif.PCWrite), 32'(0));
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z,
                      0, tbl[i].sm, tbl[i].name, seen, imm_seen);
            chk({tbl[i].name, " cycles"}, 32'(seen), 32'(tbl[i].cyc));
            chk({tbl[i].name, " immsrc"}, 32'(imm_seen), 32'(tbl[i].imm));
        end

        // Unsupported opcode traps and stays trapped until reset
        run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, "illegal op",
                  seen, imm_seen);
        for (int i = 0; i < 10; i++) begin
            mem_ready = rnd();
            Zero = rnd();
            @(negedge clk);
            chk("error hold state", 32'(cif.state_dbg), 32'(ERROR));
            chk("error hold illegal", 32'(cif.illegal), 32'(1));
            enables_off("error hold");
            @(posedge clk);
            #1;
        end
        do_reset_to_fetch("error reset");

        // Reset in the middle of a stalled store
        op = OP_SW;
        mem_ready = 1'b1;
        k = 0;
        while (cif.state_dbg != 4'(MEMWRITE) && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("sw reach MEMWRITE", 32'(cif.state_dbg), 32'(MEMWRITE));
        mem_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("sw stall memwrite", 32'(cif.MemWrite), 32'(1));
            @(posedge clk);
            #1;
        end
        do_reset_to_fetch("sw abort");

        // Random instruction stream
        for (int n = 0; n < 150; n++) begin
            run_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                      rnd(), rnd(), $urandom_range(0, 2),
                      $urandom_range(0, 3), "rand", seen, imm_seen);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
